// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle signed 32-bit restoring divider. Divides operand
//               magnitudes at one quotient bit per cycle, then applies signs.
//               Quotient truncates toward zero; remainder follows the dividend.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic [31:0] data_remainder,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  count;        // iteration counter; reused as FIX phase flag
    logic [31:0] rem_acc;      // partial remainder (always < |B|, fits 32 bits)
    logic [31:0] quo;          // dividend shifting out / quotient shifting in
    logic [31:0] div_mag;      // |B|
    logic        sign_q;
    logic        sign_r;
    logic        zero_div;

    logic        start;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        trial_ok;
    logic [31:0] neg_q;
    logic [31:0] neg_r;

    // A new operation is only accepted when no division is in flight
    assign start    = ctrl_DIV && ((state == S_IDLE) || (state == S_DONE));

    // Invert-plus-one magnitude; 0x80000000 maps to itself and is read unsigned
    assign mag_a    = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign mag_b    = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // 33-bit trial subtraction; bit 32 set means the trial went negative
    assign shifted  = {rem_acc, quo[31]};
    assign trial    = shifted - {1'b0, div_mag};
    assign trial_ok = ~trial[32];

    assign neg_q    = ~quo + 32'd1;
    assign neg_r    = ~rem_acc + 32'd1;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; FIX spends two cycles: sign fix-up, then settle
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (ctrl_DIV) begin
                    state_next = S_ITER;
                end
            end
            S_ITER: begin
                if (count == 5'd31) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                if (count != 5'd0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = ctrl_DIV ? S_ITER : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, restoring iterations and sign fix-up
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count          <= 5'd0;
            rem_acc        <= 32'd0;
            quo            <= 32'd0;
            div_mag        <= 32'd0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            zero_div       <= 1'b0;
            data_result    <= 32'd0;
            data_remainder <= 32'd0;
            data_exception <= 1'b0;
        end else if (start) begin
            count    <= 5'd0;
            rem_acc  <= 32'd0;
            quo      <= mag_a;
            div_mag  <= mag_b;
            sign_q   <= data_operandA[31] ^ data_operandB[31];
            sign_r   <= data_operandA[31];
            zero_div <= (data_operandB == 32'd0);
        end else if (state == S_ITER) begin
            count   <= count + 5'd1;
            rem_acc <= trial_ok ? trial[31:0] : shifted[31:0];
            quo     <= {quo[30:0], trial_ok};
        end else if (state == S_FIX) begin
            if (count == 5'd0) begin
                count <= 5'd1;
                if (zero_div) begin
                    data_result    <= 32'd0;
                    data_remainder <= 32'd0;
                    data_exception <= 1'b1;
                end else begin
                    data_result    <= sign_q ? neg_q : quo;
                    data_remainder <= sign_r ? neg_r : rem_acc;
                    data_exception <= 1'b0;
                end
            end else begin
                count <= 5'd0;
            end
        end
    end

    // Registered status flags derived from the upcoming state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            busy           <= (state_next == S_ITER) || (state_next == S_FIX);
            data_resultRDY <= (state_next == S_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider. Table-driven vectors and
//               hand-written protocol sequences feed a scoreboard queue that
//               is drained whenever the divider pulses data_resultRDY.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int          start_cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   busy_cnt = 0;
    logic prev_rdy = 1'b0;
    exp_t sb[$];
    vec_t vecs[10];

    seq_divider dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Free-running edge counter for latency measurement
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one cycle, sample at the falling edge and drain the scoreboard
    task automatic cycle_check();
        exp_t e;
        @(negedge clock);
        if (busy === 1'b1) busy_cnt++;
        if (data_resultRDY === 1'b1) begin
            check("rdy_single_pulse", {31'd0, prev_rdy}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", data_result, e.q);
                check("remainder", data_remainder, e.r);
                check("exception", {31'd0, data_exception}, {31'd0, e.exc});
                check("latency", cyc - e.start_cyc, 32'd34);
            end
        end
        prev_rdy = data_resultRDY;
    endtask

    task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        busy_cnt      = 0;
        cycle_check();
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic push_exp(input logic [31:0] q, input logic [31:0] r, input logic exc);
        exp_t e;
        e.q = q;
        e.r = r;
        e.exc = exc;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_empty(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) cycle_check();
        check("ready_timeout", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic run_one(input vec_t v);
        push_exp(v.q, v.r, v.exc);
        drive_start(v.a, v.b);
        wait_empty(60);
        check("busy_cycles", busy_cnt, 32'd34);
        cycle_check();
        check("held_result", data_result, v.q);
        check("held_remainder", data_remainder, v.r);
        check("held_exception", {31'd0, data_exception}, {31'd0, v.exc});
        check("rdy_low_after", {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   sa;
        int   sdv;
        int   ready_guard;

        vecs[0] = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1] = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};
        vecs[2] = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0};
        vecs[3] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0};
        vecs[4] = '{32'h12345678,  32'd0,         32'd0,         32'd0,         1'b1};
        vecs[5] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
        vecs[6] = '{32'h80000000,  32'd1,         32'h80000000,  32'd0,         1'b0};
        vecs[7] = '{32'd5,         32'd9,         32'd0,         32'd5,         1'b0};
        vecs[8] = '{32'h7FFFFFFF,  32'h80000000,  32'd0,         32'h7FFFFFFF,  1'b0};
        vecs[9] = '{32'hFFFFFFFF,  32'd2,         32'd0,         32'hFFFFFFFF,  1'b0};

        reset_n       = 1'b0;
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        cycle_check();
        cycle_check();
        ctrl_DIV = 1'b0;
        check("rst_result", data_result, 32'd0);
        check("rst_remainder", data_remainder, 32'd0);
        check("rst_exception", {31'd0, data_exception}, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        cycle_check();
        cycle_check();

        // Directed table
        for (int i = 0; i < 10; i++) run_one(vecs[i]);

        // Random operands checked against the language's own signed division
        for (int i = 0; i < 6; i++) begin
            sa  = $urandom;
            sdv = $urandom >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 1) sdv = -sdv;
            if (sdv == 0) sdv = 3;
            v.a = sa;
            v.b = sdv;
            v.q = sa / sdv;
            v.r = sa % sdv;
            v.exc = 1'b0;
            run_one(v);
        end

        // ctrl_DIV pulsed mid-iteration must be ignored
        push_exp(32'd100, 32'd0, 1'b0);
        drive_start(32'd1000, 32'd10);
        for (int i = 0; i < 5; i++) cycle_check();
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'd7;
        cycle_check();
        ctrl_DIV = 1'b0;
        wait_empty(60);
        for (int i = 0; i < 40; i++) cycle_check();

        // Back-to-back: second start issued during the DONE cycle
        push_exp(32'd14, 32'd2, 1'b0);
        drive_start(32'd100, 32'd7);
        ready_guard = 0;
        while (data_resultRDY !== 1'b1 && ready_guard < 60) begin
            cycle_check();
            ready_guard++;
        end
        check("b2b_first_ready_seen", {31'd0, data_resultRDY}, 32'd1);
        push_exp(32'd9, 32'd0, 1'b0);
        drive_start(32'd81, 32'd9);
        wait_empty(60);
        cycle_check();

        // Reset around iteration 10 aborts the operation silently
        drive_start(32'd1000, 32'd3);
        for (int i = 0; i < 10; i++) cycle_check();
        reset_n = 1'b0;
        cycle_check();
        check("midrst_result", data_result, 32'd0);
        check("midrst_remainder", data_remainder, 32'd0);
        check("midrst_exception", {31'd0, data_exception}, 32'd0);
        check("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 45; i++) cycle_check();

        run_one('{32'd6, 32'd3, 32'd2, 32'd0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
